// File: rtl/imm_encoder.sv
// Immediate encoder: packs a 32-bit immediate into the scattered immediate
// fields of a RISC-V instruction template, range-checks it, and streams the
// encoded word with an instruction-memory byte address through a two-stage
// valid/ready pipeline.
module imm_encoder #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        imm_sel,
  input  logic [31:0]       imm,
  input  logic [31:0]       base_inst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err,
  output logic [7:0]        err_count
);

  typedef enum logic [2:0] {
    FMT_I_S   = 3'b000,
    FMT_I_U   = 3'b001,
    FMT_SHAMT = 3'b010,
    FMT_S     = 3'b011,
    FMT_B     = 3'b100,
    FMT_U     = 3'b101,
    FMT_J     = 3'b110,
    FMT_BAD   = 3'b111
  } imm_fmt_e;

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  imm_fmt_e          fmt;
  logic [31:0]       enc_inst;
  logic              enc_ok;
  logic              sext_11;
  logic              sext_12;
  logic              sext_20;

  logic              s1_valid;
  logic [31:0]       s1_inst;
  logic [ADDR_W-1:0] s1_addr;
  logic              s1_err;

  logic              s2_free;
  logic              accept;
  logic [ADDR_W-1:0] addr_cnt;

  assign fmt = imm_fmt_e'(imm_sel);

  // Signed range checks reduce to "all bits above the field's sign bit equal
  // the sign bit"; e.g. sext_11 <=> -2048 <= imm <= 2047.
  assign sext_11 = (imm[31:11] == '0) || (imm[31:11] == '1);
  assign sext_12 = (imm[31:12] == '0) || (imm[31:12] == '1);
  assign sext_20 = (imm[31:20] == '0) || (imm[31:20] == '1);

  // Scatter the immediate into the selected format and decide legality;
  // illegal words pass the template through untouched.
  always_comb begin
    enc_inst = base_inst;
    enc_ok   = 1'b0;
    case (fmt)
      FMT_I_S: begin
        enc_ok          = sext_11;
        enc_inst[31:20] = imm[11:0];
      end
      FMT_I_U: begin
        enc_ok          = (imm[31:12] == '0);
        enc_inst[31:20] = imm[11:0];
      end
      FMT_SHAMT: begin
        enc_ok          = (imm[31:5] == '0);
        enc_inst[24:20] = imm[4:0];
      end
      FMT_S: begin
        enc_ok          = sext_11;
        enc_inst[31:25] = imm[11:5];
        enc_inst[11:7]  = imm[4:0];
      end
      FMT_B: begin
        enc_ok          = sext_12 && !imm[0];
        enc_inst[31]    = imm[12];
        enc_inst[7]     = imm[11];
        enc_inst[30:25] = imm[10:5];
        enc_inst[11:8]  = imm[4:1];
      end
      FMT_U: begin
        enc_ok          = (imm[11:0] == '0);
        enc_inst[31:12] = imm[31:12];
      end
      FMT_J: begin
        enc_ok          = sext_20 && !imm[0];
        enc_inst[31]    = imm[20];
        enc_inst[19:12] = imm[19:12];
        enc_inst[20]    = imm[11];
        enc_inst[30:21] = imm[10:1];
      end
      default: begin
        enc_ok = 1'b0;
      end
    endcase
    if (!enc_ok) begin
      enc_inst = base_inst;
    end
  end

  // Handshake: stage2 frees up when empty or being drained this cycle.
  always_comb begin
    s2_free  = !out_valid || out_ready;
    in_ready = !clr && (!s1_valid || s2_free);
    accept   = in_valid && in_ready;
  end

  // Stage1: capture the encoded word and its address at accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_inst  <= '0;
      s1_addr  <= BASE;
      s1_err   <= 1'b0;
    end else if (clr) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_inst  <= enc_inst;
      s1_addr  <= addr_cnt;
      s1_err   <= !enc_ok;
    end else if (s2_free) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage2: output register, held while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_addr  <= BASE;
      out_err   <= 1'b0;
    end else if (clr) begin
      out_valid <= 1'b0;
    end else if (s2_free) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_inst <= s1_inst;
        out_addr <= s1_addr;
        out_err  <= s1_err;
      end
    end
  end

  // Address counter: advances only on accepted legal words, wraps to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt <= BASE;
    end else if (clr) begin
      addr_cnt <= BASE;
    end else if (accept && enc_ok) begin
      addr_cnt <= addr_cnt + ADDR_STEP;
    end
  end

  // Saturating count of error words taken in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (clr) begin
      err_count <= '0;
    end else if (accept && !enc_ok && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Self-checking bench for imm_encoder: directed test-plan vectors plus a
// randomized run scored against an arithmetic reference model.
module tb_imm_encoder;

  localparam logic [9:0] BASE = 10'h100;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  imm_sel;
  logic [31:0] imm;
  logic [31:0] base_inst;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [9:0]  out_addr;
  logic        out_err;
  logic [7:0]  err_count;

  logic        b_in_valid;
  logic        b_in_ready;
  logic        b_out_valid;
  logic [31:0] b_out_inst;
  logic [3:0]  b_out_addr;
  logic        b_out_err;
  logic [7:0]  b_err_count;

  imm_encoder #(.ADDR_W(10), .BASE_ADDR(32'h100)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .imm_sel(imm_sel), .imm(imm), .base_inst(base_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err),
    .err_count(err_count)
  );

  imm_encoder #(.ADDR_W(4), .BASE_ADDR(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clr(1'b0),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .imm_sel(3'b000), .imm(32'd7), .base_inst(32'h00000013),
    .out_valid(b_out_valid), .out_ready(1'b1),
    .out_inst(b_out_inst), .out_addr(b_out_addr), .out_err(b_out_err),
    .err_count(b_err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] inst;
    logic [9:0]  addr;
    bit          err;
  } exp_t;

  exp_t        q[$];
  logic [9:0]  m_addr;
  int          m_errs;
  bit          last_acc;
  bit          hold_pending;
  bit          clr_prev;
  logic [31:0] held_inst;
  logic [9:0]  held_addr;
  logic        held_err;

  // Reference encoder written directly from the format table with plain
  // integer range tests.
  function automatic void model_enc(input logic [2:0] sel, input logic [31:0] im,
                                    input logic [31:0] bs, output logic [31:0] inst,
                                    output bit ok);
    longint s;
    longint u;
    s = $signed(im);
    u = im;
    inst = bs;
    case (sel)
      3'd0: begin ok = (s >= -2048) && (s <= 2047); inst[31:20] = im[11:0]; end
      3'd1: begin ok = (u <= 4095); inst[31:20] = im[11:0]; end
      3'd2: begin ok = (u <= 31); inst[24:20] = im[4:0]; end
      3'd3: begin
        ok = (s >= -2048) && (s <= 2047);
        inst[31:25] = im[11:5]; inst[11:7] = im[4:0];
      end
      3'd4: begin
        ok = (s >= -4096) && (s <= 4094) && (u % 2 == 0);
        inst[31] = im[12]; inst[7] = im[11]; inst[30:25] = im[10:5]; inst[11:8] = im[4:1];
      end
      3'd5: begin ok = (u % 4096 == 0); inst[31:12] = im[31:12]; end
      3'd6: begin
        ok = (s >= -1048576) && (s <= 1048574) && (u % 2 == 0);
        inst[31] = im[20]; inst[19:12] = im[19:12]; inst[20] = im[11]; inst[30:21] = im[10:1];
      end
      default: ok = 1'b0;
    endcase
    if (!ok) inst = bs;
  endfunction

  // One clock of stimulus on the main DUT with full scoreboard checks.
  task automatic cycle(input bit v, input logic [2:0] sel, input logic [31:0] im,
                       input logic [31:0] bs, input bit ordy, input bit cl);
    int          occ;
    exp_t        e;
    logic [31:0] mi;
    bit          ok;
    @(negedge clk);
    in_valid = v; imm_sel = sel; imm = im; base_inst = bs; out_ready = ordy; clr = cl;
    #1;
    occ = q.size();
    check_eq("err_count", err_count, m_errs);
    if (clr_prev) check_eq("clr_out_valid", out_valid, 0);
    if (hold_pending) begin
      check_eq("hold_valid", out_valid, 1);
      check_eq("hold_inst", out_inst, held_inst);
      check_eq("hold_addr", out_addr, held_addr);
      check_eq("hold_err", out_err, held_err);
    end
    check_eq("in_ready", in_ready, (!cl && (occ < 2 || ordy)));
    if (out_valid && ordy) begin
      if (q.size() == 0) begin
        check_eq("spurious_out", out_valid, 0);
      end else begin
        e = q.pop_front();
        check_eq("sb_inst", out_inst, e.inst);
        check_eq("sb_addr", out_addr, e.addr);
        check_eq("sb_err", out_err, e.err);
      end
    end
    hold_pending = out_valid && !ordy && !cl;
    held_inst = out_inst; held_addr = out_addr; held_err = out_err;
    clr_prev = cl;
    last_acc = 1'b0;
    if (cl) begin
      q.delete();
      m_addr = BASE;
      m_errs = 0;
    end else if (v && in_ready) begin
      model_enc(sel, im, bs, mi, ok);
      e.inst = mi; e.addr = m_addr; e.err = !ok;
      q.push_back(e);
      last_acc = 1'b1;
      if (ok) m_addr = m_addr + 10'd4;
      else if (m_errs < 255) m_errs++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 3'd0, 32'd0, 32'd0, 1, 0);
  endtask

  task automatic drain();
    for (int c = 0; c < 10 && q.size() > 0; c++) cycle(0, 3'd0, 32'd0, 32'd0, 1, 0);
    check_eq("drain_empty", q.size(), 0);
  endtask

  // Push one word into an empty pipeline and check it two cycles later.
  task automatic single(input string tag, input logic [2:0] sel, input logic [31:0] im,
                        input logic [31:0] bs, input logic [31:0] exp_inst, input bit exp_err);
    cycle(1, sel, im, bs, 1, 0);
    cycle(0, 3'd0, 32'd0, 32'd0, 1, 0);
    cycle(0, 3'd0, 32'd0, 32'd0, 1, 0);
    check_eq({tag, "_valid"}, out_valid, 1);
    check_eq({tag, "_inst"}, out_inst, exp_inst);
    check_eq({tag, "_err"}, out_err, exp_err);
  endtask

  int bnd [20] = '{0, 1, 2, 3, 31, 32, 2047, 2048, -2048, -2049, 4094, 4095, 4096,
                   -4096, -4098, 1048574, 1048575, 1048576, -1048576, -1048578};

  function automatic logic [31:0] pick_imm();
    int t;
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: begin t = int'($urandom_range(0, 10000)) - 5000; return t; end
      2: return bnd[$urandom_range(0, 19)];
      default: return $urandom & 32'hFFFFF000;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int nb;
    logic [3:0] b_exp [5];
    rst_n = 1'b1; clr = 1'b0; in_valid = 1'b0; imm_sel = 3'd0; imm = '0;
    base_inst = '0; out_ready = 1'b1; b_in_valid = 1'b0;
    m_addr = BASE; m_errs = 0; hold_pending = 0; clr_prev = 0; last_acc = 0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_inst", out_inst, 0);
    check_eq("rst_out_addr", out_addr, BASE);
    check_eq("rst_out_err", out_err, 0);
    check_eq("rst_err_count", err_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Latency and first word
    cycle(1, 3'd0, 32'hFFFFFFFF, 32'h00000093, 1, 0);
    cycle(0, 3'd0, 32'd0, 32'd0, 1, 0);
    check_eq("lat1_valid", out_valid, 0);
    cycle(0, 3'd0, 32'd0, 32'd0, 1, 0);
    check_eq("lat2_valid", out_valid, 1);
    check_eq("ti_inst", out_inst, 32'hFFF00093);
    check_eq("ti_addr", out_addr, BASE);
    check_eq("ti_err", out_err, 0);

    single("b", 3'd4, 32'hFFFFFFFC, 32'h00000063, 32'hFE000EE3, 0);
    single("j", 3'd6, 32'h00000800, 32'h000000EF, 32'h001000EF, 0);
    check_eq("j_addr", out_addr, BASE + 10'd8);
    single("u", 3'd5, 32'h12345000, 32'h000002B7, 32'h123452B7, 0);
    single("u_bad", 3'd5, 32'h12345001, 32'h000002B7, 32'h000002B7, 1);
    check_eq("u_bad_addr", out_addr, BASE + 10'd16);
    idle(1);
    check_eq("u_bad_errcnt", err_count, 1);
    single("i_2048", 3'd0, 32'd2048, 32'h00000093, 32'h00000093, 1);
    single("shamt_32", 3'd2, 32'd32, 32'h00001013, 32'h00001013, 1);
    single("b_odd", 3'd4, 32'd3, 32'h00000063, 32'h00000063, 1);
    single("sel7", 3'd7, 32'd0, 32'h12345678, 32'h12345678, 1);
    single("shamt_31", 3'd2, 32'd31, 32'h40005013, 32'h41F05013, 0);
    check_eq("after_err_addr", out_addr, BASE + 10'd16);

    // clr mid-stream
    cycle(1, 3'd0, 32'd1, 32'h13, 1, 0);
    cycle(1, 3'd0, 32'd2, 32'h13, 1, 0);
    cycle(1, 3'd0, 32'd3, 32'h13, 1, 1);
    cycle(0, 3'd0, 32'd0, 32'd0, 1, 0);
    single("post_clr", 3'd0, 32'd5, 32'h13, 32'h00500013, 0);
    check_eq("post_clr_addr", out_addr, BASE);
    drain();

    // Backpressure: only two words fit while the consumer stalls
    k = 0;
    for (int c = 0; c < 4; c++) begin
      cycle(1, 3'd0, 32'(k), 32'h13, 0, 0);
      if (last_acc) k++;
    end
    check_eq("bp_accepts", k, 2);
    for (int c = 0; c < 20 && k < 4; c++) begin
      cycle(1, 3'd0, 32'(k), 32'h13, 1, 0);
      if (last_acc) k++;
    end
    check_eq("bp_all", k, 4);
    drain();

    // Error counter saturation
    for (int i = 0; i < 300; i++) cycle(1, 3'd7, $urandom, $urandom, 1, 0);
    idle(3);
    check_eq("err_sat", err_count, 255);
    cycle(0, 3'd0, 32'd0, 32'd0, 1, 1);
    idle(2);

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 4) != 0, 3'($urandom_range(0, 7)), pick_imm(), $urandom,
            $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    end
    drain();

    // Asynchronous reset while stalled
    for (int i = 0; i < 3; i++) cycle(1, 3'd0, 32'd9, 32'h13, 0, 0);
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check_eq("mrst_out_valid", out_valid, 0);
    check_eq("mrst_out_inst", out_inst, 0);
    check_eq("mrst_out_addr", out_addr, BASE);
    check_eq("mrst_out_err", out_err, 0);
    check_eq("mrst_err_count", err_count, 0);
    q.delete(); m_addr = BASE; m_errs = 0; hold_pending = 0; clr_prev = 0;
    #1 rst_n = 1'b1;
    single("post_rst", 3'd1, 32'd4095, 32'h13, 32'hFFF00013, 0);
    check_eq("post_rst_addr", out_addr, BASE);
    drain();

    // Narrow-address instance: wrap goes to zero, not to BASE_ADDR
    b_exp = '{4'd4, 4'd8, 4'd12, 4'd0, 4'd4};
    nb = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      b_in_valid = (i < 5);
      #1;
      if (b_out_valid) begin
        if (nb < 5) check_eq("wrap_addr", b_out_addr, b_exp[nb]);
        nb++;
      end
    end
    b_in_valid = 1'b0;
    check_eq("wrap_count", nb, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
